square_motion_ctrl: RTL and testbench

- Animation controller for the single-square demo.
- Once per frame, during vertical blanking, it moves a SIZE×SIZE square by a programmable step and bounces it off the screen edges.
- Every pixel clock it produces a registered "inside square" flag from the timing generator's sx/sy.
- Sits between the 480p timing generator and the paint/colour logic. Position updates only in blanking, so no tearing.

---
 rtl/square_motion_ctrl.sv | 150 +++++++++++++++
 tb/tb_square_motion_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/square_motion_ctrl.sv
// Bouncing-square animation controller: moves a SIZE x SIZE square once per
// FRAME_DIV frames during vertical blanking and flags pixels inside it.
module square_motion_ctrl #(
  parameter int CORDW     = 10,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int SIZE      = 200,
  parameter int X0        = 220,
  parameter int Y0        = 140,
  parameter int FRAME_DIV = 1
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             run,
  input  logic [3:0]       speed,
  output logic [CORDW-1:0] qx,
  output logic [CORDW-1:0] qy,
  output logic             square,
  output logic             busy,
  output logic             frame_tick
);

  localparam int W   = CORDW + 1;
  localparam int FCW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [W-1:0]   X_MAX   = W'(H_RES - SIZE);
  localparam logic [W-1:0]   Y_MAX   = W'(V_RES - SIZE);
  localparam logic [FCW-1:0] FC_LAST = FCW'(FRAME_DIV - 1);

  typedef enum logic [1:0] {S_WAIT, S_CALC_X, S_CALC_Y, S_COMMIT} state_t;
  typedef enum logic {DIR_NEG = 1'b0, DIR_POS = 1'b1} dir_t;

  typedef struct packed {
    logic [CORDW-1:0] pos;
    dir_t             dir;
  } step_t;

  state_t           r_state, w_state_next;
  dir_t             r_dir_x, r_dir_y, r_ndx, r_ndy;
  logic [CORDW-1:0] r_qx, r_qy, r_nx, r_ny;
  logic [3:0]       r_spd;
  logic [FCW-1:0]   r_frame_cnt;
  logic             r_square, r_frame_tick;
  logic             w_strobe, w_advance, w_start, w_inside;
  step_t            w_step_x, w_step_y;

  // One axis of motion; sums are one bit wider than a coordinate so they never wrap.
  function automatic step_t bounce(input logic [CORDW-1:0] pos, input dir_t dir,
                                   input logic [3:0] spd, input logic [W-1:0] lim);
    step_t        w_res;
    logic [W-1:0] w_pos, w_spd, w_sum, w_diff;
    w_pos     = {1'b0, pos};
    w_spd     = W'(spd);
    w_sum     = w_pos + w_spd;
    w_diff    = w_pos - w_spd;
    w_res.pos = pos;
    w_res.dir = dir;
    if (spd != 4'd0) begin
      if (dir == DIR_POS) begin
        if (w_sum >= lim) begin
          w_res.pos = lim[CORDW-1:0];
          w_res.dir = DIR_NEG;
        end else begin
          w_res.pos = w_sum[CORDW-1:0];
        end
      end else begin
        if (w_pos <= w_spd) begin
          w_res.pos = '0;
          w_res.dir = DIR_POS;
        end else begin
          w_res.pos = w_diff[CORDW-1:0];
        end
      end
    end
    return w_res;
  endfunction

  assign w_strobe  = (sx == '0) && (sy == CORDW'(V_RES));
  assign w_advance = (r_state == S_WAIT) && w_strobe && run;
  assign w_start   = w_advance && (r_frame_cnt == FC_LAST);
  assign w_step_x  = bounce(r_qx, r_dir_x, r_spd, X_MAX);
  assign w_step_y  = bounce(r_qy, r_dir_y, r_spd, Y_MAX);

  assign w_inside = ({1'b0, sx} >= {1'b0, r_qx}) && ({1'b0, sx} < ({1'b0, r_qx} + W'(SIZE))) &&
                    ({1'b0, sy} >= {1'b0, r_qy}) && ({1'b0, sy} < ({1'b0, r_qy} + W'(SIZE)));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) r_state <= S_WAIT;
    else         r_state <= w_state_next;
  end

  // NOTE: default assigned first so no path through the case infers a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_WAIT:   if (w_start) w_state_next = S_CALC_X;
      S_CALC_X: w_state_next = S_CALC_Y;
      S_CALC_Y: w_state_next = S_COMMIT;
      S_COMMIT: w_state_next = S_WAIT;
      default:  w_state_next = S_WAIT;
    endcase
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_qx         <= CORDW'(X0);
      r_qy         <= CORDW'(Y0);
      r_dir_x      <= DIR_POS;
      r_dir_y      <= DIR_POS;
      r_nx         <= '0;
      r_ny         <= '0;
      r_ndx        <= DIR_POS;
      r_ndy        <= DIR_POS;
      r_spd        <= '0;
      r_frame_cnt  <= '0;
      r_square     <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_square     <= w_inside;
      r_frame_tick <= (r_state == S_COMMIT);
      if (w_advance) r_frame_cnt <= w_start ? '0 : r_frame_cnt + 1'b1;
      if (w_start)   r_spd <= speed;
      if (r_state == S_CALC_X) begin
        r_nx  <= w_step_x.pos;
        r_ndx <= w_step_x.dir;
      end
      if (r_state == S_CALC_Y) begin
        r_ny  <= w_step_y.pos;
        r_ndy <= w_step_y.dir;
      end
      // Position only changes here, well inside blanking.
      if (r_state == S_COMMIT) begin
        r_qx    <= r_nx;
        r_qy    <= r_ny;
        r_dir_x <= r_ndx;
        r_dir_y <= r_ndy;
      end
    end
  end

  assign qx         = r_qx;
  assign qy         = r_qy;
  assign square     = r_square;
  assign busy       = (r_state != S_WAIT);
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_square_motion_ctrl.sv
// Directed bench for square_motion_ctrl: three instances cover default
// placement, a right-wall preset and frame division.
module tb_square_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst_a, rst_b, rst_c;
  logic       run_a, run_b, run_c;
  logic [9:0] sx, sy;
  logic [3:0] speed;
  logic [9:0] qx_a, qy_a, qx_b, qy_b, qx_c, qy_c;
  logic       sq_a, sq_b, sq_c, busy_a, busy_b, busy_c, ft_a, ft_b, ft_c;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int ticks_a  = 0;
  int ticks_c  = 0;
  int t0;
  int exp_c[9] = '{220, 220, 221, 221, 221, 222, 222, 222, 223};

  always #5 clk = ~clk;

  square_motion_ctrl dut_a (
    .clk_pix(clk), .rst_pix(rst_a), .sx(sx), .sy(sy), .run(run_a), .speed(speed),
    .qx(qx_a), .qy(qy_a), .square(sq_a), .busy(busy_a), .frame_tick(ft_a));

  square_motion_ctrl #(.X0(438), .Y0(100)) dut_b (
    .clk_pix(clk), .rst_pix(rst_b), .sx(sx), .sy(sy), .run(run_b), .speed(speed),
    .qx(qx_b), .qy(qy_b), .square(sq_b), .busy(busy_b), .frame_tick(ft_b));

  square_motion_ctrl #(.FRAME_DIV(3)) dut_c (
    .clk_pix(clk), .rst_pix(rst_c), .sx(sx), .sy(sy), .run(run_c), .speed(speed),
    .qx(qx_c), .qy(qy_c), .square(sq_c), .busy(busy_c), .frame_tick(ft_c));

  always @(negedge clk) begin
    if (ft_a === 1'b1) ticks_a <= ticks_a + 1;
    if (ft_c === 1'b1) ticks_c <= ticks_c + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present the blanking strobe for one cycle; returns at strobe+1.
  task automatic strobe();
    sx = 10'd0;
    sy = 10'd480;
    @(negedge clk);
    sx = 10'd1;
  endtask

  // Returns at strobe+4, where a committed update is visible.
  task automatic update();
    strobe();
    wait_cyc(3);
  endtask

  initial begin
    sx = 10'd0; sy = 10'd0; speed = 4'd2;
    run_a = 1'b0; run_b = 1'b0; run_c = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    wait_cyc(3);
    check("rst_qx_a", qx_a, 220);
    check("rst_qy_a", qy_a, 140);
    check("rst_busy_a", busy_a, 0);
    check("rst_ft_a", ft_a, 0);
    check("rst_sq_a", sq_a, 0);
    check("rst_qx_b", qx_b, 438);
    check("rst_qy_b", qy_b, 100);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    wait_cyc(1);

    // Inside-square flag, one cycle of latency, half-open bounds.
    sx = 10'd220; sy = 10'd140; wait_cyc(1); check("sq_220_140", sq_a, 1);
    sx = 10'd219;               wait_cyc(1); check("sq_219_140", sq_a, 0);
    sx = 10'd420;               wait_cyc(1); check("sq_420_140", sq_a, 0);
    sx = 10'd419; sy = 10'd339; wait_cyc(1); check("sq_419_339", sq_a, 1);
    sy = 10'd340;               wait_cyc(1); check("sq_419_340", sq_a, 0);

    // One update at speed 2 with latency and busy window.
    run_a = 1'b1; speed = 4'd2;
    strobe();
    check("busy_t1", busy_a, 1);
    wait_cyc(1); check("busy_t2", busy_a, 1);
    wait_cyc(1); check("busy_t3", busy_a, 1);
    check("ft_t3", ft_a, 0);
    check("qx_t3", qx_a, 220);
    wait_cyc(1);
    check("ft_t4", ft_a, 1);
    check("busy_t4", busy_a, 0);
    check("qx_t4", qx_a, 222);
    check("qy_t4", qy_a, 142);
    wait_cyc(1); check("ft_t5", ft_a, 0);

    // Frozen across three strobes.
    run_a = 1'b0;
    t0 = ticks_a;
    update(); update(); update();
    wait_cyc(1);
    check("frz_qx", qx_a, 222);
    check("frz_qy", qy_a, 142);
    check("frz_ticks", ticks_a - t0, 0);

    // Reset during CALC_Y abandons the update.
    run_a = 1'b1;
    t0 = ticks_a;
    strobe();
    wait_cyc(1);
    check("mid_busy", busy_a, 1);
    rst_a = 1'b1;
    wait_cyc(1);
    check("mid_qx", qx_a, 220);
    check("mid_qy", qy_a, 140);
    check("mid_busy_after", busy_a, 0);
    rst_a = 1'b0;
    run_a = 1'b0;
    wait_cyc(3);
    check("mid_ticks", ticks_a - t0, 0);
    check("mid_qx_hold", qx_a, 220);

    // Right-wall clamp, speed 0 at the wall, then walk to the left wall.
    run_b = 1'b1; speed = 4'd3;
    update(); check("rw_qx", qx_b, 440); check("rw_qy", qy_b, 103);
    speed = 4'd0;
    update(); check("sp0_qx", qx_b, 440); check("sp0_qy", qy_b, 103);
    speed = 4'd3;
    update(); check("lft_qx", qx_b, 437); check("lft_qy", qy_b, 106);
    speed = 4'd15;
    repeat (30) update();
    check("lw_qx", qx_b, 0);
    check("lw_qy", qy_b, 10);
    speed = 4'd5;
    update(); check("lw1_qx", qx_b, 5);  check("lw1_qy", qy_b, 5);
    update(); check("lw2_qx", qx_b, 10); check("lw2_qy", qy_b, 0);
    update(); check("lw3_qx", qx_b, 15); check("lw3_qy", qy_b, 5);
    run_b = 1'b0;

    // Frame division by 3.
    run_c = 1'b1; speed = 4'd1;
    t0 = ticks_c;
    for (int i = 0; i < 9; i++) begin
      update();
      check($sformatf("fd_qx_%0d", i + 1), qx_c, exp_c[i]);
    end
    wait_cyc(1);
    check("fd_ticks", ticks_c - t0, 3);
    check("fd_qy", qy_c, 143);
    run_c = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
